// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment count controller: register map,
// CTRL bit positions, default clamp bound and prescaler state encoding.
package seg7_pkg;

  localparam logic [1:0] REG_VALUE    = 2'd0;
  localparam logic [1:0] REG_CTRL     = 2'd1;
  localparam logic [1:0] REG_PRESCALE = 2'd2;
  localparam logic [1:0] REG_STATUS   = 2'd3;

  localparam int CTRL_RUN  = 0;
  localparam int CTRL_DOWN = 1;
  localparam int CTRL_WRAP = 2;
  localparam int CTRL_W    = 3;

  localparam int MAX_VALUE_DEF = 9999;

  typedef enum logic {
    PS_IDLE  = 1'b0,
    PS_COUNT = 1'b1
  } ps_state_e;

endpackage

// File: rtl/seg7_prescaler.sv
// Tick generator: holds the reload value while idle, counts down while running
// and pulses tick for one cycle each time the count passes through zero.
module seg7_prescaler
  import seg7_pkg::*;
#(
  parameter int          PRESCALE_W   = 26,
  parameter int unsigned PRESCALE_RST = 49999999
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] reload,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  ps_state_e             state;

  // The state bit is the RUN flag registered in the owner's CTRL register.
  assign state = run ? PS_COUNT : PS_IDLE;

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= PRESCALE_W'(PRESCALE_RST);
    else        cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    case (state)
      PS_IDLE:  cnt_d = reload;
      PS_COUNT: begin
        if (restart) begin
          cnt_d = reload;
        end else if (cnt_q == '0) begin
          cnt_d = reload;
          tick  = 1'b1;
        end else begin
          cnt_d = cnt_q - PRESCALE_W'(1);
        end
      end
      default:  cnt_d = reload;
    endcase
  end

endmodule

// File: rtl/seg7_count_ctrl.sv
// Bus-mapped owner of the 4-digit display value: direct writes, clamped
// up/down decimal counting with sticky LIMIT. Optional compare IRQ under
// SEG7_CMP_IRQ_EN.
module seg7_count_ctrl
  import seg7_pkg::*;
#(
  parameter int          DATA_W       = 32,
  parameter int          VAL_W        = 16,
  parameter int          MAX_VALUE    = MAX_VALUE_DEF,
  parameter int          PRESCALE_W   = 26,
  parameter int unsigned PRESCALE_RST = 49999999
) (
  input  logic              clock_50MHz,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              we,
  input  logic              re,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [VAL_W-1:0]  displayed_number
`ifdef SEG7_CMP_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam logic [VAL_W-1:0]  MAX_V = VAL_W'(MAX_VALUE);
  localparam logic [DATA_W-1:0] MAX_D = DATA_W'(MAX_VALUE);

  logic [VAL_W-1:0]      value_q, value_d;
  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  limit_q, limit_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [DATA_W-1:0]     status_rd;
  logic wr, rd, wr_value, wr_ctrl, wr_pre, wr_stat;
  logic tick, tick_eff, limit_evt, restart;

  assign wr       = sel & we;
  assign rd       = sel & re;
  assign wr_value = wr & (addr == REG_VALUE);
  assign wr_ctrl  = wr & (addr == REG_CTRL);
  assign wr_pre   = wr & (addr == REG_PRESCALE);
  assign wr_stat  = wr & (addr == REG_STATUS);
  assign restart  = wr_ctrl & wdata[CTRL_RUN] & ~ctrl_q[CTRL_RUN];
  // A direct VALUE write drops the coincident tick, including its limit effects.
  assign tick_eff = tick & ~wr_value;

  seg7_prescaler #(
    .PRESCALE_W  (PRESCALE_W),
    .PRESCALE_RST(PRESCALE_RST)
  ) u_prescaler (
    .clk    (clock_50MHz),
    .rst_n  (rst_n),
    .run    (ctrl_q[CTRL_RUN]),
    .restart(restart),
    .reload (prescale_q),
    .tick   (tick)
  );

`ifdef SEG7_CMP_IRQ_EN
  logic [VAL_W-1:0] cmp_q, cmp_d, val_prev_q;
  logic             irq_q, irq_d;

  always_ff @(posedge clock_50MHz) begin
    if (!rst_n) begin
      cmp_q      <= '0;
      val_prev_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      cmp_q      <= cmp_d;
      val_prev_q <= value_q;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    cmp_d = cmp_q;
    if (wr_stat) cmp_d = wdata[VAL_W+15:16];
    irq_d = (irq_q & ~(wr_stat & wdata[1])) |
            ((value_q == cmp_q) & (value_q != val_prev_q));
  end

  always_comb begin
    status_rd              = '0;
    status_rd[0]           = limit_q;
    status_rd[1]           = irq_q;
    status_rd[VAL_W+15:16] = cmp_q;
  end

  assign irq = irq_q;
`else
  assign status_rd = DATA_W'(limit_q);
`endif

  always_ff @(posedge clock_50MHz) begin
    if (!rst_n) begin
      value_q    <= '0;
      ctrl_q     <= '0;
      prescale_q <= PRESCALE_W'(PRESCALE_RST);
      limit_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      value_q    <= value_d;
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      limit_q    <= limit_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    value_d    = value_q;
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    limit_evt  = 1'b0;
    rdata_d    = rdata_q;

    if (tick_eff) begin
      if (!ctrl_q[CTRL_DOWN]) begin
        if (value_q < MAX_V) begin
          value_d = value_q + VAL_W'(1);
        end else begin
          limit_evt = 1'b1;
          if (ctrl_q[CTRL_WRAP]) value_d = '0;
          else                   ctrl_d[CTRL_RUN] = 1'b0;
        end
      end else begin
        if (value_q != '0) begin
          value_d = value_q - VAL_W'(1);
        end else begin
          limit_evt = 1'b1;
          if (ctrl_q[CTRL_WRAP]) value_d = MAX_V;
          else                   ctrl_d[CTRL_RUN] = 1'b0;
        end
      end
    end

    // Clamp at full bus width so large writes saturate instead of truncating.
    if (wr_value) value_d = (wdata > MAX_D) ? MAX_V : wdata[VAL_W-1:0];
    if (wr_ctrl)  ctrl_d = wdata[CTRL_W-1:0];
    if (wr_pre)   prescale_d = wdata[PRESCALE_W-1:0];
    limit_d = (limit_q & ~(wr_stat & wdata[0])) | limit_evt;

    if (rd) begin
      case (addr)
        REG_VALUE:    rdata_d = DATA_W'(value_q);
        REG_CTRL:     rdata_d = DATA_W'(ctrl_q);
        REG_PRESCALE: rdata_d = DATA_W'(prescale_q);
        default:      rdata_d = status_rd;
      endcase
    end
  end

  assign rdata            = rdata_q;
  assign displayed_number = value_q;

endmodule

// File: tb/tb_seg7_count_ctrl.sv
// Directed bench for seg7_count_ctrl: register access, clamping, counting,
// limit handling, write/tick priority, reset mid-count and (if enabled) irq.
module tb_seg7_count_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, sel, we, re;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata, rv;
  logic [15:0] disp;
`ifdef SEG7_CMP_IRQ_EN
  logic        irq;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #10 clk = ~clk;

  seg7_count_ctrl dut (
    .clock_50MHz     (clk),
    .rst_n           (rst_n),
    .sel             (sel),
    .we              (we),
    .re              (re),
    .addr            (addr),
    .wdata           (wdata),
    .rdata           (rdata),
    .displayed_number(disp)
`ifdef SEG7_CMP_IRQ_EN
    ,
    .irq             (irq)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Both tasks start and end just after a falling edge.
  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; re = 1'b1; addr = a;
    @(negedge clk);
    sel = 1'b0; re = 1'b0;
    d = rdata;
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; we = 1'b0; re = 1'b0; addr = 2'd0; wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_disp", {16'd0, disp}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    rd_reg(2'd0, rv); chk("reset_value", rv, 32'd0);
    rd_reg(2'd1, rv); chk("reset_ctrl", rv, 32'd0);
    rd_reg(2'd2, rv); chk("reset_prescale", rv, 32'd49999999);
    rd_reg(2'd3, rv); chk("reset_status", rv, 32'd0);

    wr_reg(2'd0, 32'd1234);       chk("wr_1234", {16'd0, disp}, 32'd1234);
    wr_reg(2'd0, 32'h0001_0005);  chk("wr_clamp_wide", {16'd0, disp}, 32'd9999);
    wr_reg(2'd0, 32'd10000);      chk("wr_clamp_10000", {16'd0, disp}, 32'd9999);
    wr_reg(2'd0, 32'd42);
    rd_reg(2'd0, rv);             chk("rd_value", rv, 32'd42);

    // Up count with wrap, prescale 3: tick every 4 cycles after the CTRL edge.
    wr_reg(2'd2, 32'd3);
    wr_reg(2'd0, 32'd9998);
    wr_reg(2'd1, 32'd5);
    repeat (3) @(negedge clk);    chk("wrap_before", {16'd0, disp}, 32'd9998);
    @(negedge clk);               chk("wrap_9999", {16'd0, disp}, 32'd9999);
    repeat (3) @(negedge clk);    chk("wrap_hold", {16'd0, disp}, 32'd9999);
    @(negedge clk);               chk("wrap_zero", {16'd0, disp}, 32'd0);
    wr_reg(2'd1, 32'd0);
    rd_reg(2'd3, rv);             chk("wrap_limit", rv, 32'd1);
    wr_reg(2'd3, 32'd1);
    rd_reg(2'd3, rv);             chk("limit_clear", rv, 32'd0);

    // Down count, no wrap, prescale 0: 1 -> 0 then limit stops RUN.
    wr_reg(2'd2, 32'd0);
    wr_reg(2'd0, 32'd1);
    wr_reg(2'd1, 32'd3);          chk("down_start", {16'd0, disp}, 32'd1);
    @(negedge clk);               chk("down_zero", {16'd0, disp}, 32'd0);
    repeat (3) @(negedge clk);    chk("down_hold", {16'd0, disp}, 32'd0);
    rd_reg(2'd1, rv);             chk("down_run_cleared", rv, 32'd2);
    rd_reg(2'd3, rv);             chk("down_limit", rv, 32'd1);
    wr_reg(2'd3, 32'd1);

    // STATUS clear coinciding with a limit event: set wins.
    wr_reg(2'd0, 32'd9999);
    wr_reg(2'd1, 32'd1);
    wr_reg(2'd3, 32'd1);
    rd_reg(2'd3, rv);             chk("limit_set_wins", rv, 32'd1);
    rd_reg(2'd1, rv);             chk("up_run_cleared", rv, 32'd0);
    chk("up_hold_max", {16'd0, disp}, 32'd9999);
    wr_reg(2'd3, 32'd1);

    // VALUE write on a tick cycle wins, then counting resumes from it.
    wr_reg(2'd0, 32'd10);
    wr_reg(2'd1, 32'd1);          chk("run_start", {16'd0, disp}, 32'd10);
    wr_reg(2'd0, 32'd500);        chk("wr_on_tick", {16'd0, disp}, 32'd500);
    @(negedge clk);               chk("after_wr_tick", {16'd0, disp}, 32'd501);
    rd_reg(2'd1, rv);             chk("run_readback", rv, 32'd1);
    chk("count_502", {16'd0, disp}, 32'd502);
    rst_n = 1'b0;
    @(negedge clk);               chk("midrst_disp", {16'd0, disp}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);    chk("midrst_idle", {16'd0, disp}, 32'd0);
    rd_reg(2'd1, rv);             chk("midrst_ctrl", rv, 32'd0);
    rd_reg(2'd2, rv);             chk("midrst_prescale", rv, 32'd49999999);

`ifdef SEG7_CMP_IRQ_EN
    chk("irq_reset", {31'd0, irq}, 32'd0);
    wr_reg(2'd2, 32'd0);
    wr_reg(2'd3, 32'h0005_0000);
    wr_reg(2'd0, 32'd3);
    wr_reg(2'd1, 32'd1);
    @(negedge clk);
    @(negedge clk);               chk("irq_val5", {16'd0, disp}, 32'd5);
    chk("irq_not_yet", {31'd0, irq}, 32'd0);
    @(negedge clk);               chk("irq_rise", {31'd0, irq}, 32'd1);
    wr_reg(2'd1, 32'd0);
    rd_reg(2'd3, rv);             chk("irq_status", rv, 32'h0005_0002);
    wr_reg(2'd3, 32'd2);
    @(negedge clk);               chk("irq_clear", {31'd0, irq}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
